// File: rtl/seg7_encoder_if.sv
// Segment-tap bus: raw active-low segments in, recovered code report out under valid/ready.
interface seg7_encoder_if;
  logic [6:0] SegIn;
  logic [3:0] Code;
  logic       Err;
  logic       Valid;
  logic       Ready;
  logic       Overrun;

  modport master (
    input  SegIn,
    input  Ready,
    output Code,
    output Err,
    output Valid,
    output Overrun
  );

  modport slave (
    output SegIn,
    output Ready,
    input  Code,
    input  Err,
    input  Valid,
    input  Overrun
  );
endinterface

// File: rtl/seg7_encoder.sv
// Recovers the 4-bit symbol from an active-low 7-segment bus; reports each new stable pattern once.
// Valid rises 1+STABLE_CYCLES edges after the first sampling edge of a held pattern; Ready consumes it.
module seg7_encoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic           Clock,
  input  logic           Resetn,
  seg7_encoder_if.master bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       s1;
  logic [6:0]       s2;
  logic [6:0]       last;
  logic [CNT_W-1:0] cnt;
  logic [0:0]       state;
  logic [3:0]       code_q;
  logic             err_q;
  logic             ovr_q;

  logic             accept;
  logic [6:0]       lit;
  logic [3:0]       enc_code;
  logic             enc_err;

  // s1 != s2 means s2 changes at this edge, so the counter restarts with it.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      s1  <= 7'h7F;
      s2  <= 7'h7F;
      cnt <= '0;
    end else begin
      s1 <= bus.SegIn;
      s2 <= s1;
      if (s1 != s2) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Fires on the edge where the counter steps to STABLE_CYCLES with s2 held.
  assign accept = (cnt == CNT_PRE) && (s1 == s2) && (s2 != last);

  always_comb begin
    lit      = ~s2;
    enc_code = 4'hE;
    enc_err  = 1'b1;
    case (lit)
      7'b0111111: begin enc_code = 4'h0; enc_err = 1'b0; end
      7'b0000110: begin enc_code = 4'h1; enc_err = 1'b0; end
      7'b1011011: begin enc_code = 4'h2; enc_err = 1'b0; end
      7'b1001111: begin enc_code = 4'h3; enc_err = 1'b0; end
      7'b1100110: begin enc_code = 4'h4; enc_err = 1'b0; end
      7'b1101101: begin enc_code = 4'h5; enc_err = 1'b0; end
      7'b1111101: begin enc_code = 4'h6; enc_err = 1'b0; end
      7'b0000111: begin enc_code = 4'h7; enc_err = 1'b0; end
      7'b1111111: begin enc_code = 4'h8; enc_err = 1'b0; end
      7'b1101111: begin enc_code = 4'h9; enc_err = 1'b0; end
      7'b1110001: begin enc_code = 4'hA; enc_err = 1'b0; end
      7'b0111110: begin enc_code = 4'hB; enc_err = 1'b0; end
      7'b0111001: begin enc_code = 4'hC; enc_err = 1'b0; end
      7'b0000000: begin enc_code = 4'hF; enc_err = 1'b0; end
      default:    begin enc_code = 4'hE; enc_err = 1'b1; end
    endcase
  end

  // A dropped report still updates last so the same pattern is not re-reported later.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state  <= IDLE;
      code_q <= 4'hF;
      err_q  <= 1'b0;
      ovr_q  <= 1'b0;
      last   <= 7'h7F;
    end else begin
      if (accept) begin
        last <= s2;
        if (state == IDLE || bus.Ready) begin
          state  <= PEND;
          code_q <= enc_code;
          err_q  <= enc_err;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (state == PEND && bus.Ready) begin
        state <= IDLE;
      end
    end
  end

  assign bus.Code    = code_q;
  assign bus.Err     = err_q;
  assign bus.Valid   = (state == PEND);
  assign bus.Overrun = ovr_q;

endmodule
